// File: rtl/sum_sched_pkg.sv
// Shared constants and FSM state type for the round-robin three-operand summing scheduler.
package sum_sched_pkg;

    localparam int W_DEF    = 16;
    localparam int NREQ_DEF = 3;
    localparam int ID_W     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SUM  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/sum_sched_sum3_stage.sv
// Registered three-operand unsigned adder; W+2 result bits so no carry is lost.
module sum3_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W+1:0] s
);

    // One-cycle adder pipeline register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= {2'b00, a} + {2'b00, b} + {2'b00, c};
        end
    end

endmodule

// File: rtl/sum_sched.sv
// Round-robin arbiter plus sequencing FSM: grants one requester, sums its three
// operands through a registered adder and presents the result with a ready/valid handshake.
//
// state | meaning
// IDLE  | waiting for any req_valid; grant and capture happen here
// CALC  | captured operands feed the adder stage
// SUM   | adder result loaded into the response registers
// RESP  | rsp_valid high, held until rsp_ready
module sum_sched
    import sum_sched_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_d,
    input  logic [NREQ*W-1:0] req_f,
    input  logic [NREQ*W-1:0] req_g,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_ovf,
    output logic              busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_gid;
    logic [ID_W-1:0] r_rsp_id;
    logic [W-1:0]    r_op_d;
    logic [W-1:0]    r_op_f;
    logic [W-1:0]    r_op_g;
    logic [W-1:0]    r_rsp_sum;
    logic            r_rsp_ovf;
    logic [W+1:0]    w_add_s;
    logic [ID_W:0]   w_pick;
    logic [ID_W-1:0] w_grant;
    logic [ID_W-1:0] w_rr_nxt;
    logic            w_found;
    logic            w_accept;

    // Lowest offset from ptr wins, so scan offsets high-to-low and let later hits overwrite.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [ID_W-1:0] ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx_l;
        int              idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_l = idx[ID_W-1:0];
            if (valid[idx_l]) res = {1'b1, idx_l};
        end
        return res;
    endfunction

    assign w_pick   = rr_pick(req_valid, r_rr_ptr);
    assign w_found  = w_pick[ID_W];
    assign w_grant  = w_pick[ID_W-1:0];
    assign w_rr_nxt = (w_grant == ID_W'(NREQ - 1)) ? '0 : w_grant + 1'b1;

    sum3_stage #(.W(W)) u_sum3 (
        .clk (clk),
        .rst (rst),
        .a   (r_op_d),
        .b   (r_op_f),
        .c   (r_op_g),
        .s   (w_add_s)
    );

    // Next-state and grant decode; accepts only from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC:    w_state_nxt = SUM;
            SUM:     w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture at grant, pointer advance, and response load in SUM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_gid     <= '0;
            r_op_d    <= '0;
            r_op_f    <= '0;
            r_op_g    <= '0;
            r_rsp_id  <= '0;
            r_rsp_sum <= '0;
            r_rsp_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_d   <= req_d[int'(w_grant)*W +: W];
                r_op_f   <= req_f[int'(w_grant)*W +: W];
                r_op_g   <= req_g[int'(w_grant)*W +: W];
                r_gid    <= w_grant;
                r_rr_ptr <= w_rr_nxt;
            end
            if (r_state == SUM) begin
                r_rsp_sum <= w_add_s[W-1:0];
                r_rsp_ovf <= |w_add_s[W+1:W];
                r_rsp_id  <= r_gid;
            end
        end
    end

    // Reset masks the accept so no ready escapes during a reset cycle.
    assign req_ready = (w_accept && !rst) ? (NREQ'(1) << w_grant) : '0;
    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_ovf   = r_rsp_ovf;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sum_sched.sv
// Randomized bench for sum_sched against a transaction-level reference model.
module tb_sum_sched;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [47:0] req_d;
    logic [47:0] req_f;
    logic [47:0] req_g;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_ovf;
    logic        busy;

    int n_checks;
    int n_errors;
    int model_ptr;

    sum_sched #(.W(16), .NREQ(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_d     (req_d),
        .req_f     (req_f),
        .req_g     (req_g),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [2:0] mask, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (mask[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic scramble_inputs();
        req_valid = 3'($urandom);
        req_d     = 48'({$urandom(), $urandom()});
        req_f     = 48'({$urandom(), $urandom()});
        req_g     = 48'({$urandom(), $urandom()});
    endtask

    // One full transaction: grant, two busy cycles, response, optional backpressure.
    // With abort set, reset is applied during the first RESP cycle instead.
    task automatic run_txn(input logic [2:0] mask, input logic [47:0] vd, input logic [47:0] vf,
                           input logic [47:0] vg, input int hold, input bit abort);
        int          g;
        int unsigned total;
        logic [15:0] e_sum;
        logic        e_ovf;
        g     = model_grant(mask, model_ptr);
        total = int'(vd[g*16 +: 16]) + int'(vf[g*16 +: 16]) + int'(vg[g*16 +: 16]);
        e_sum = total[15:0];
        e_ovf = (total >= 32'd65536);

        @(negedge clk);
        req_valid = mask; req_d = vd; req_f = vf; req_g = vg; rsp_ready = 1'b0;
        #1;
        chk("grant_ready", 32'(req_ready), 32'(3'b001 << g));
        chk("idle_busy", 32'(busy), 32'd0);
        model_ptr = (g + 1) % 3;

        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            scramble_inputs();
            #1;
            chk("pipe_ready", 32'(req_ready), 32'd0);
            chk("pipe_valid", 32'(rsp_valid), 32'd0);
            chk("pipe_busy", 32'(busy), 32'd1);
        end

        @(negedge clk);
        scramble_inputs();
        rsp_ready = (hold == 0) && !abort;
        rst = abort;
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_sum", 32'(rsp_sum), 32'(e_sum));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e_ovf));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        if (abort) chk("rst_ready", 32'(req_ready), 32'd0);

        if (abort) begin
            @(negedge clk);
            rst = 1'b0; req_valid = 3'b000; rsp_ready = 1'b0;
            #1;
            chk("abort_valid", 32'(rsp_valid), 32'd0);
            chk("abort_sum", 32'(rsp_sum), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            model_ptr = 0;
            return;
        end

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            scramble_inputs();
            rsp_ready = (h == hold - 1);
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_sum", 32'(rsp_sum), 32'(e_sum));
            chk("hold_ovf", 32'(rsp_ovf), 32'(e_ovf));
            chk("hold_id", 32'(rsp_id), 32'(g));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end

        @(negedge clk);
        req_valid = 3'b000; rsp_ready = 1'b0;
        #1;
        chk("back_idle", 32'(busy), 32'd0);
        chk("back_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 3'b111;
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sum", 32'(rsp_sum), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_ovf", 32'(rsp_ovf), 32'd0);
        rst = 1'b0; req_valid = 3'b000;
        model_ptr = 0;
    endtask

    function automatic logic [47:0] rnd48();
        return 48'({$urandom(), $urandom()});
    endfunction

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        model_ptr = 0;
        rst       = 1'b1;
        req_valid = 3'b000;
        req_d     = '0;
        req_f     = '0;
        req_g     = '0;
        rsp_ready = 1'b0;

        apply_reset();

        // idle with no requests leaves pointer alone
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 3'b000;
            #1;
            chk("noreq_ready", 32'(req_ready), 32'd0);
            chk("noreq_busy", 32'(busy), 32'd0);
        end

        // basic sum on requester 0
        run_txn(3'b001, 48'h0000_0000_0001, 48'h0000_0000_0002, 48'h0000_0000_0003, 0, 1'b0);
        // overflow on requester 1
        run_txn(3'b010, 48'h0000_FFFF_0000, 48'h0000_FFFF_0000, 48'h0000_FFFF_0000, 0, 1'b0);

        // fairness from a fresh pointer
        apply_reset();
        for (int i = 0; i < 6; i++) run_txn(3'b111, rnd48(), rnd48(), rnd48(), 0, 1'b0);

        // wrap: pointer at 2 with only 0 and 1 requesting
        run_txn(3'b111, rnd48(), rnd48(), rnd48(), 0, 1'b0);
        run_txn(3'b111, rnd48(), rnd48(), rnd48(), 0, 1'b0);
        run_txn(3'b011, rnd48(), rnd48(), rnd48(), 0, 1'b0);
        run_txn(3'b111, rnd48(), rnd48(), rnd48(), 0, 1'b0);

        // backpressure
        run_txn(3'b100, rnd48(), rnd48(), rnd48(), 5, 1'b0);

        // reset in RESP, then next grant from 0
        run_txn(3'b110, rnd48(), rnd48(), rnd48(), 0, 1'b1);
        run_txn(3'b111, rnd48(), rnd48(), rnd48(), 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_txn(3'($urandom_range(1, 7)), rnd48(), rnd48(), rnd48(),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sum_sched.md
SUM_SCHED -- requirements
Module: sum_sched

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the operand and result width.
REQ-002 The block SHALL have parameter NREQ, default 3, giving the number of requesters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester request strobe.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester accept, one-hot or zero.
REQ-007 The block SHALL have ports req_d, req_f and req_g, each input, NREQ*W bits: per-requester operands; requester i occupies bits [i*W +: W].
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port rsp_id, output, 2 bits: index of the requester that owns the result.
REQ-011 The block SHALL have port rsp_sum, output, W bits: result, equal to (d+f+g) mod 2^W.
REQ-012 The block SHALL have port rsp_ovf, output, 1 bit: high when the true d+f+g is at least 2^W.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, CALC, SUM, RESP.
REQ-015 In IDLE with any req_valid high, the block SHALL grant round-robin: the first valid index at or after rr_ptr, searching upward modulo NREQ.
REQ-016 In the grant cycle, req_ready[grant] SHALL be high combinationally in that same cycle, and all other req_ready bits SHALL be low.
REQ-017 At that clock edge the block SHALL capture the operands and the grant index, set rr_ptr to (grant+1) mod NREQ, and move to CALC.
REQ-018 req_ready SHALL be all-zero in every state other than IDLE.
REQ-019 In CALC the block SHALL drive the captured operands to the adder stage, and the adder stage SHALL register the (W+2)-bit sum at the edge; the FSM then moves to SUM.
REQ-020 SUM SHALL last one cycle, load rsp_sum, rsp_ovf and rsp_id into output registers, and move to RESP.
REQ-021 rsp_valid SHALL be high exactly in RESP, which is the third cycle after the accept cycle.
REQ-022 rsp_sum, rsp_ovf and rsp_id SHALL stay stable throughout RESP.
REQ-023 In RESP with rsp_ready high, the FSM SHALL move to IDLE; a new grant is possible in the following cycle at the earliest, giving a minimum of 4 cycles per transaction.
REQ-024 In RESP with rsp_ready low, the FSM SHALL hold RESP indefinitely.
REQ-025 Requesters SHALL hold req_valid and their operands stable until they see req_ready; a valid that drops without a ready SHALL be ignored without error.
REQ-026 The block SHALL ignore changes to req_valid or operands outside IDLE.
REQ-027 With no req_valid in IDLE, the block SHALL stay in IDLE with rr_ptr unchanged.
REQ-028 Arithmetic SHALL be unsigned: sum = d+f+g computed at W+2 bits, rsp_sum = low W bits, rsp_ovf = OR of the top 2 bits.
REQ-029 rr_ptr SHALL wrap from NREQ-1 to 0.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL set: state = IDLE, rr_ptr = 0, rsp_valid = 0, rsp_sum = 0, rsp_ovf = 0, rsp_id = 0, captured operands = 0, adder register = 0.
REQ-031 req_ready SHALL be 0 during any cycle in which rst is high.
REQ-032 Reset in any state, including RESP mid-handshake, SHALL discard the transaction without producing a response.
REQ-033 rst SHALL have priority over every other input.

Structure
REQ-034 Package sum_sched_pkg SHALL hold W_DEF=16, NREQ_DEF=3, ID_W=2, and the state enum (IDLE, CALC, SUM, RESP).
REQ-035 The registered three-operand adder SHALL be a separate sub-module, sum3_stage (ports clk, rst, a, b, c, s[W+1:0]), with one-cycle latency and reset to 0.
REQ-036 The arbiter and FSM SHALL reside in sum_sched.

Verification
REQ-037 Single request: req_valid=001, d=1, f=2, g=3, rsp_ready=1. The bench SHALL see req_ready=001 in cycle T, rsp_valid in cycle T+3, rsp_sum=6, rsp_id=0, rsp_ovf=0.
REQ-038 Overflow: d=f=g=16'hFFFF. The bench SHALL see rsp_sum=16'hFFFD and rsp_ovf=1.
REQ-039 Fairness: req_valid=111 held with rsp_ready=1. The bench SHALL see grants in the order 0,1,2,0,1,2, and rsp_id in the same order.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles in RESP. The bench SHALL see rsp_valid and its data held constant, req_ready=000 and busy=1 throughout, and IDLE one cycle after rsp_ready=1.
REQ-041 Reset in RESP: the bench SHALL see, in the next cycle, rsp_valid=0, rsp_sum=0, busy=0, and the next grant going to requester 0 when req_valid=111.
REQ-042 Wrap: rr_ptr=2 with req_valid=011. The bench SHALL see requester 0 granted and rr_ptr become 1.
